flac_frame_crc16: RTL
=====================

FLAC_FRAME_CRC16 -- requirements
Module: flac_frame_crc16

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, on ports iClock and iReset.
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- iClock  in  1  clock; all state changes on posedge
- iReset  in  1  asynchronous active-high reset
- iStart  in  1  start pulse, sampled on posedge
- iAddressStart  in  16  first frame word address
- iAddressEnd  in  16  last frame word address, inclusive (the encoder's final oAddress)
- iOddByte  in  1  1 = last word holds only its upper byte
- iMemory  in  16  read data for the oAddress presented in the previous cycle
- oAddress  out  16  shared read/write address
- oMemory  out  16  write data
- oWriteEnable  out  1  write strobe; memory commits oMemory to oAddress on the following negedge
- oCrc  out  16  final CRC value
- done  out  1  high while in DONE

Function
REQ-003 The CRC SHALL be CRC-16, polynomial 0x8005, initial value 0x0000, no reflection, no final XOR.
REQ-004 Bytes SHALL be processed MSB-first: word[15:8] first, then word[7:0].
REQ-005 A full word SHALL be absorbed in one cycle, using a 16-bit unrolled update.
REQ-006 States SHALL be IDLE, RUN, WRITE_HI, WRITE_LO and DONE.
REQ-007 In IDLE or DONE, on iStart=1 the block SHALL:
- latch iAddressStart, iAddressEnd and iOddByte;
- clear the CRC to 0x0000;
- set oAddress to iAddressStart;
- deassert done;
- enter RUN.
REQ-008 In RUN, each posedge SHALL absorb iMemory as the word at the current oAddress and increment oAddress by 1.
REQ-009 RUN SHALL absorb both bytes of every word except the last word when iOddByte=1, where it absorbs only iMemory[15:8] and saves that byte.
REQ-010 After absorbing the word at the latched end address, the block SHALL leave RUN:
- iOddByte=0: enter WRITE_LO with oAddress = end+1;
- iOddByte=1: enter WRITE_HI with oAddress = end.
REQ-011 In WRITE_HI the block SHALL drive oMemory = {saved byte, crc[15:8]} and oWriteEnable=1 for one cycle, then enter WRITE_LO with oAddress = end+1.
REQ-012 In WRITE_LO the block SHALL drive oWriteEnable=1 for one cycle, then enter DONE:
- iOddByte=1: oMemory = {crc[7:0], 8'h00};
- iOddByte=0: oMemory = crc.
REQ-013 In DONE the block SHALL hold done=1, oCrc = final CRC, and oAddress = last written address, until the next iStart or reset.
REQ-014 Latency SHALL be N cycles in RUN (N = end-start+1, mod 2^16; start=end means one word), plus 1 write cycle (even) or 2 write cycles (odd).
REQ-015 Address arithmetic SHALL wrap modulo 2^16; end < start is a wrapped range, and end=0xFFFF places the CRC at 0x0000.
REQ-016 iStart SHALL be ignored in RUN, WRITE_HI and WRITE_LO.
REQ-017 oWriteEnable SHALL be 0 in every state other than WRITE_HI and WRITE_LO.
REQ-018 Input address changes after iStart SHALL have no effect until the next start.

Reset
REQ-019 iReset=1 SHALL immediately force:
- state = IDLE;
- oAddress, oMemory, oCrc and the internal CRC = 0;
- oWriteEnable = 0, done = 0.
REQ-020 Reset asserted mid-operation SHALL abort the operation with no further write strobe; a fresh iStart after release SHALL restart cleanly.

Structure
REQ-021 The shared FLAC package SHALL hold:
- the polynomial constant 0x8005;
- the CRC width of 16;
- the state encoding;
- the byte-wise CRC-16 update function, reused by the later frame-header CRC-8/CRC-16 blocks.
REQ-022 The combinational 16-bit CRC step SHALL be one sub-module, flac_crc16_step (inputs: crc, data word, byte-count 1/2; output: next crc); everything else SHALL stay in flac_frame_crc16.

Verification
REQ-023 The bench SHALL use a negedge-driven memory model (read data updated at negedge from oAddress; write committed at negedge when oWriteEnable=1) and SHALL cover:
- single word 0x0000 at address 0, iOddByte=0 -> mem[1]=0x0000, oCrc=0x0000, done after 2 RUN/WRITE cycles;
- single word 0x0001 at address 0, iOddByte=0 -> mem[1]=0x8005, oCrc=0x8005;
- words 0x3132,0x3334,0x3536,0x3738,0x3900 at addresses 10..14, iOddByte=1 -> oCrc=0xFEE8, mem[14]=0x39FE, mem[15]=0xE800;
- start=0xFFFE, end=0xFFFF with words 0x3132,0x3334, iOddByte=0 -> CRC written at 0x0000, oWriteEnable asserted exactly once;
- iReset pulsed during RUN of a 36-word frame -> done=0, no write observed, outputs zero; re-issued iStart produces the same CRC as an uninterrupted run;
- iStart pulsed during RUN -> ignored, result identical to a single-start run.

Source files
------------

// File: rtl/flac_frame_crc16_pkg.sv
// Shared FLAC CRC definitions: polynomial, width, frame-CRC state encoding and
// the byte-wise CRC-16 update reused by the frame-header CRC blocks.
package flac_frame_crc16_pkg;

  localparam int                 CRC16_WIDTH = 16;
  localparam logic [CRC16_WIDTH-1:0] CRC16_POLY = 16'h8005;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WRITE_HI,
    ST_WRITE_LO,
    ST_DONE
  } state_t;

  // MSB-first, non-reflected CRC-16 over one byte.
  function automatic logic [CRC16_WIDTH-1:0] crc16_byte(input logic [CRC16_WIDTH-1:0] crc,
                                                         input logic [7:0]             data);
    logic [CRC16_WIDTH-1:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[CRC16_WIDTH-1] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/flac_frame_crc16_if.sv
// Memory/control bundle between a host (master) and the frame CRC engine (slave).
interface flac_frame_crc16_if;
  logic        start;
  logic [15:0] address_start;
  logic [15:0] address_end;
  logic        odd_byte;
  logic [15:0] memory_rd;
  logic [15:0] address;
  logic [15:0] memory_wr;
  logic        write_enable;
  logic [15:0] crc;
  logic        done;

  modport master (
    output start, address_start, address_end, odd_byte, memory_rd,
    input  address, memory_wr, write_enable, crc, done
  );

  modport slave (
    input  start, address_start, address_end, odd_byte, memory_rd,
    output address, memory_wr, write_enable, crc, done
  );
endinterface

// File: rtl/flac_frame_crc16_step.sv
// Combinational CRC-16 step absorbing one or two bytes (upper byte first) of a word.
module flac_crc16_step
  import flac_frame_crc16_pkg::*;
(
  input  logic [CRC16_WIDTH-1:0] crc,
  input  logic [15:0]            data,
  input  logic [1:0]             byte_count,
  output logic [CRC16_WIDTH-1:0] crc_next
);

  logic [CRC16_WIDTH-1:0] crc_hi;

  always_comb begin
    crc_hi   = crc16_byte(crc, data[15:8]);
    crc_next = (byte_count == 2'd1) ? crc_hi : crc16_byte(crc_hi, data[7:0]);
  end

endmodule

// File: rtl/flac_frame_crc16.sv
// Reads a frame word range, accumulates CRC-16 and appends it big-endian right
// after the last data byte (which may share a word with the CRC high byte).
module flac_frame_crc16
  import flac_frame_crc16_pkg::*;
(
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [15:0] iAddressStart,
  input  logic [15:0] iAddressEnd,
  input  logic        iOddByte,
  input  logic [15:0] iMemory,
  output logic [15:0] oAddress,
  output logic [15:0] oMemory,
  output logic        oWriteEnable,
  output logic [15:0] oCrc,
  output logic        done
);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] end_q, end_d;
  logic        odd_q, odd_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  saved_q, saved_d;

  logic        last_word;
  logic [1:0]  step_bytes;
  logic [15:0] crc_step;

  assign last_word  = (addr_q == end_q);
  assign step_bytes = (last_word && odd_q) ? 2'd1 : 2'd2;

  flac_crc16_step u_step (
    .crc        (crc_q),
    .data       (iMemory),
    .byte_count (step_bytes),
    .crc_next   (crc_step)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    end_d        = end_q;
    odd_d        = odd_q;
    crc_d        = crc_q;
    saved_d      = saved_q;
    oMemory      = 16'h0000;
    oWriteEnable = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iStart) begin
          state_d = ST_RUN;
          addr_d  = iAddressStart;
          end_d   = iAddressEnd;
          odd_d   = iOddByte;
          crc_d   = 16'h0000;
          saved_d = 8'h00;
        end
      end
      ST_RUN: begin
        crc_d = crc_step;
        if (last_word && odd_q) begin
          // Last data byte stays in the word; the CRC high byte joins it.
          saved_d = iMemory[15:8];
          state_d = ST_WRITE_HI;
        end else if (last_word) begin
          addr_d  = addr_q + 16'd1;
          state_d = ST_WRITE_LO;
        end else begin
          addr_d  = addr_q + 16'd1;
        end
      end
      ST_WRITE_HI: begin
        oMemory      = {saved_q, crc_q[15:8]};
        oWriteEnable = 1'b1;
        addr_d       = addr_q + 16'd1;
        state_d      = ST_WRITE_LO;
      end
      ST_WRITE_LO: begin
        oMemory      = odd_q ? {crc_q[7:0], 8'h00} : crc_q;
        oWriteEnable = 1'b1;
        state_d      = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      addr_q  <= 16'h0000;
      end_q   <= 16'h0000;
      odd_q   <= 1'b0;
      crc_q   <= 16'h0000;
      saved_q <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      odd_q   <= odd_d;
      crc_q   <= crc_d;
      saved_q <= saved_d;
    end
  end

  assign oAddress = addr_q;
  assign oCrc     = crc_q;
  assign done     = (state_q == ST_DONE);

endmodule
